// File: rtl/hazard_sched_pkg.sv
// Shared types and encodings for the pipeline hazard scheduler.
package hazard_sched_pkg;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_LU_STALL = 2'd1,
    ST_MEM_WAIT = 2'd2
  } state_t;

  localparam logic [1:0] RES_SRC_LOAD = 2'b01;

  localparam logic [1:0] FWD_RF = 2'b00;
  localparam logic [1:0] FWD_WB = 2'b01;

  // Select the writeback result when writeback targets this non-x0 source.
  function automatic logic [1:0] fwd_sel(input logic wr, input logic [4:0] rd,
                                         input logic [4:0] rs);
    return (wr && (rd != 5'd0) && (rd == rs)) ? FWD_WB : FWD_RF;
  endfunction

endpackage

// File: rtl/hazard_sched_if.sv
// Pipeline-to-scheduler bundle: register ids and memory status in,
// stall/flush/forward controls out.
interface hazard_sched_if;
  logic [4:0] rs1_d, rs2_d;
  logic [4:0] rs1_e, rs2_e, rd_e;
  logic       reg_write_e;
  logic [1:0] res_src_e;
  logic       pc_src_e;
  logic [4:0] rd_w;
  logic       reg_write_w;
  logic       dmem_req_w, dmem_ready_w;
  logic       stall_f, stall_d, stall_e;
  logic       flush_d, flush_e;
  logic [1:0] fwd_a_e, fwd_b_e;
  logic       wb_en_w;

  modport master (
    output rs1_d, rs2_d, rs1_e, rs2_e, rd_e, reg_write_e, res_src_e, pc_src_e,
           rd_w, reg_write_w, dmem_req_w, dmem_ready_w,
    input  stall_f, stall_d, stall_e, flush_d, flush_e, fwd_a_e, fwd_b_e, wb_en_w
  );

  modport slave (
    input  rs1_d, rs2_d, rs1_e, rs2_e, rd_e, reg_write_e, res_src_e, pc_src_e,
           rd_w, reg_write_w, dmem_req_w, dmem_ready_w,
    output stall_f, stall_d, stall_e, flush_d, flush_e, fwd_a_e, fwd_b_e, wb_en_w
  );
endinterface

// File: rtl/hazard_perf_cnt.sv
// Free-running hazard event counters; each wraps modulo 2^CNT_WIDTH.
module hazard_perf_cnt #(
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 stall_evt,
  input  logic                 flush_evt,
  input  logic                 lu_evt,
  output logic [CNT_WIDTH-1:0] stall_cnt,
  output logic [CNT_WIDTH-1:0] flush_cnt,
  output logic [CNT_WIDTH-1:0] lu_cnt
);

  // Bump each counter once per cycle in which its event is present.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
      lu_cnt    <= '0;
    end else begin
      if (stall_evt) stall_cnt <= stall_cnt + 1'b1;
      if (flush_evt) flush_cnt <= flush_cnt + 1'b1;
      if (lu_evt)    lu_cnt    <= lu_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/hazard_sched.sv
// Pipeline hazard scheduler: load-use bubbles, branch flushes, data-memory
// wait stalls with a sticky timeout, and writeback forwarding select.
// Optional perf counters are built when HAZARD_PERF_EN is defined.
//
//   state       | meaning
//   ------------+------------------------------------------------
//   ST_RUN      | no hazard held from the previous cycle
//   ST_LU_STALL | one load-use bubble was just inserted
//   ST_MEM_WAIT | data memory access outstanding, whole pipe held
//
// Controls are combinational from state and inputs and forced low while
// rst_n is low. The wait counter counts consecutive memory-hazard cycles,
// so it equals N during the Nth cycle spent in ST_MEM_WAIT.
module hazard_sched
  import hazard_sched_pkg::*;
#(
  parameter int MAX_WAIT  = 255,
  parameter int CNT_WIDTH = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  hazard_sched_if.slave hz,
  output logic          mem_timeout,
  output logic [1:0]    state_o
`ifdef HAZARD_PERF_EN
  ,
  output logic [CNT_WIDTH-1:0] stall_cnt,
  output logic [CNT_WIDTH-1:0] flush_cnt,
  output logic [CNT_WIDTH-1:0] lu_cnt
`endif
);

  localparam int WAIT_W = (MAX_WAIT < 2) ? 1 : $clog2(MAX_WAIT + 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MAX_WAIT);

  if (MAX_WAIT < 1 || CNT_WIDTH < 1) begin : g_param_check
    $error("hazard_sched: MAX_WAIT and CNT_WIDTH must be at least 1");
  end

  state_t            state_q, state_nxt;
  logic [WAIT_W-1:0] wait_cnt;
  logic              timeout_q;
  logic              mem_haz, load_use;
  logic              stall_f, stall_d, stall_e, flush_d, flush_e, wb_en;
  logic              br_evt, lu_evt;
  logic [1:0]        fwd_a, fwd_b;

  assign mem_haz  = hz.dmem_req_w && !hz.dmem_ready_w;
  assign load_use = (hz.res_src_e == RES_SRC_LOAD) && hz.reg_write_e && (hz.rd_e != 5'd0)
                    && ((hz.rd_e == hz.rs1_d) || (hz.rd_e == hz.rs2_d));

  // Prioritised hazard resolution: memory wait, then redirect, then load-use.
  always_comb begin
    stall_f   = 1'b0;
    stall_d   = 1'b0;
    stall_e   = 1'b0;
    flush_d   = 1'b0;
    flush_e   = 1'b0;
    br_evt    = 1'b0;
    lu_evt    = 1'b0;
    state_nxt = ST_RUN;
    if (mem_haz) begin
      stall_f   = 1'b1;
      stall_d   = 1'b1;
      stall_e   = 1'b1;
      state_nxt = ST_MEM_WAIT;
    end else if (hz.pc_src_e) begin
      flush_d = 1'b1;
      flush_e = 1'b1;
      br_evt  = 1'b1;
    end else if (load_use) begin
      stall_f   = 1'b1;
      stall_d   = 1'b1;
      flush_e   = 1'b1;
      lu_evt    = 1'b1;
      state_nxt = ST_LU_STALL;
    end
    wb_en = !mem_haz;
    fwd_a = fwd_sel(hz.reg_write_w, hz.rd_w, hz.rs1_e);
    fwd_b = fwd_sel(hz.reg_write_w, hz.rd_w, hz.rs2_e);
    if (!rst_n) begin
      stall_f = 1'b0;
      stall_d = 1'b0;
      stall_e = 1'b0;
      flush_d = 1'b0;
      flush_e = 1'b0;
      br_evt  = 1'b0;
      lu_evt  = 1'b0;
      wb_en   = 1'b0;
      fwd_a   = FWD_RF;
      fwd_b   = FWD_RF;
    end
  end

  assign hz.stall_f = stall_f;
  assign hz.stall_d = stall_d;
  assign hz.stall_e = stall_e;
  assign hz.flush_d = flush_d;
  assign hz.flush_e = flush_e;
  assign hz.fwd_a_e = fwd_a;
  assign hz.fwd_b_e = fwd_b;
  assign hz.wb_en_w = wb_en;

  assign state_o     = state_q;
  assign mem_timeout = timeout_q || (wait_cnt == WAIT_MAX);

  // State register, saturating wait counter and sticky timeout flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_RUN;
      wait_cnt  <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q <= state_nxt;
      if (mem_haz) begin
        if (wait_cnt != WAIT_MAX) wait_cnt <= wait_cnt + 1'b1;
      end else begin
        wait_cnt <= '0;
      end
      if (wait_cnt == WAIT_MAX) timeout_q <= 1'b1;
    end
  end

`ifdef HAZARD_PERF_EN
  hazard_perf_cnt #(.CNT_WIDTH(CNT_WIDTH)) u_perf (
    .clk       (clk),
    .rst_n     (rst_n),
    .stall_evt (stall_f),
    .flush_evt (br_evt),
    .lu_evt    (lu_evt),
    .stall_cnt (stall_cnt),
    .flush_cnt (flush_cnt),
    .lu_cnt    (lu_cnt)
  );
`endif

endmodule

// File: tb/tb_hazard_sched.sv
// Directed bench for hazard_sched with MAX_WAIT=4 and 3-bit perf counters.
module tb_hazard_sched;
  logic clk = 1'b0;
  logic rst_n;
  logic mem_timeout;
  logic [1:0] state_o;
  int errors = 0;
  int checks = 0;

  hazard_sched_if hz ();

`ifdef HAZARD_PERF_EN
  logic [2:0] stall_cnt, flush_cnt, lu_cnt;
`endif

  hazard_sched #(.MAX_WAIT(4), .CNT_WIDTH(3)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .hz          (hz),
    .mem_timeout (mem_timeout),
    .state_o     (state_o)
`ifdef HAZARD_PERF_EN
    ,
    .stall_cnt   (stall_cnt),
    .flush_cnt   (flush_cnt),
    .lu_cnt      (lu_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic idle();
    hz.rs1_d = 0; hz.rs2_d = 0; hz.rs1_e = 0; hz.rs2_e = 0; hz.rd_e = 0;
    hz.reg_write_e = 0; hz.res_src_e = 2'b00; hz.pc_src_e = 0;
    hz.rd_w = 0; hz.reg_write_w = 0; hz.dmem_req_w = 0; hz.dmem_ready_w = 0;
  endtask

  task automatic load_e(input logic [4:0] rd);
    hz.res_src_e = 2'b01; hz.reg_write_e = 1; hz.rd_e = rd;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // {stall_f, stall_d, stall_e, flush_d, flush_e, wb_en_w}
  function automatic logic [5:0] ctl();
    return {hz.stall_f, hz.stall_d, hz.stall_e, hz.flush_d, hz.flush_e, hz.wb_en_w};
  endfunction

  initial begin
    // Reset with every hazard input active: controls must stay low.
    rst_n = 0;
    idle();
    hz.dmem_req_w = 1; hz.pc_src_e = 1; hz.reg_write_w = 1; hz.rd_w = 3; hz.rs1_e = 3; hz.rs2_e = 3;
    repeat (2) @(posedge clk);
    #1;
    check("rst_ctl", ctl(), 6'b000000);
    check("rst_fwd", {hz.fwd_a_e, hz.fwd_b_e}, 4'b0000);
    check("rst_state", state_o, 2'd0);
    check("rst_timeout", mem_timeout, 1'b0);
    idle();
    rst_n = 1;
    step();
    check("idle_ctl", ctl(), 6'b000001);

    // Load to x5 in E, rs1_d=5: single bubble, then forward from W.
    load_e(5); hz.rs1_d = 5;
    #1;
    check("lu_ctl", ctl(), 6'b110011);
    step();
    check("lu_state", state_o, 2'd1);
    idle();
    hz.reg_write_w = 1; hz.rd_w = 5; hz.rs1_e = 5; hz.rs2_e = 6;
    #1;
    check("lu_after_ctl", ctl(), 6'b000001);
    check("lu_fwd_a", hz.fwd_a_e, 2'b01);
    check("lu_fwd_b", hz.fwd_b_e, 2'b00);
    step();
    check("lu_back_run", state_o, 2'd0);

    // Load-use via rs2, repeated while in LU_STALL; forward on rs2_e.
    idle();
    load_e(7); hz.rs2_d = 7;
    #1;
    check("lu_rs2_ctl", ctl(), 6'b110011);
    step();
    check("lu_rs2_ctl_again", ctl(), 6'b110011);
    step();
    check("lu_rs2_state", state_o, 2'd1);
    idle();
    hz.reg_write_w = 1; hz.rd_w = 7; hz.rs2_e = 7;
    #1;
    check("fwd_b_wb", {hz.fwd_a_e, hz.fwd_b_e}, 4'b0001);
    step();

    // Branch taken together with load-use: flush wins, no stall.
    idle();
    load_e(5); hz.rs1_d = 5; hz.pc_src_e = 1;
    #1;
    check("br_lu_ctl", ctl(), 6'b000111);
    step();
    check("br_lu_state", state_o, 2'd0);

    // Memory wait of three cycles, branch present but outranked.
    idle();
    hz.dmem_req_w = 1; hz.pc_src_e = 1;
    #1;
    check("mw1_ctl", ctl(), 6'b111000);
    step();
    check("mw2_ctl", ctl(), 6'b111000);
    check("mw2_state", state_o, 2'd2);
    hz.pc_src_e = 0;
    step();
    check("mw3_ctl", ctl(), 6'b111000);
    step();
    hz.dmem_ready_w = 1;
    #1;
    check("mw_ready_ctl", ctl(), 6'b000001);
    check("mw_no_timeout", mem_timeout, 1'b0);
    step();
    check("mw_exit_state", state_o, 2'd0);

    // rd_e = x0 load never stalls; rd_w = x0 never forwards.
    idle();
    load_e(0); hz.rs1_d = 0; hz.reg_write_w = 1; hz.rd_w = 0; hz.rs1_e = 0;
    #1;
    check("x0_ctl", ctl(), 6'b000001);
    check("x0_fwd", {hz.fwd_a_e, hz.fwd_b_e}, 4'b0000);
    hz.reg_write_w = 0; hz.rd_w = 9; hz.rs1_e = 9;
    #1;
    check("nowrite_fwd", hz.fwd_a_e, 2'b00);
    step();

    // Ready never arrives: timeout from 4th wait cycle, sticky afterwards.
    idle();
    hz.dmem_req_w = 1;
    #1;
    check("to_c0", mem_timeout, 1'b0);
    step();
    check("to_w1", mem_timeout, 1'b0);
    step();
    check("to_w2", mem_timeout, 1'b0);
    step();
    check("to_w3", mem_timeout, 1'b0);
    step();
    check("to_w4", mem_timeout, 1'b1);
    step();
    check("to_w5", mem_timeout, 1'b1);
    check("to_w5_ctl", ctl(), 6'b111000);
    // Exit cycle also honours a branch.
    hz.dmem_ready_w = 1; hz.pc_src_e = 1;
    #1;
    check("to_exit_br", ctl(), 6'b000111);
    step();
    idle();
    #1;
    check("to_sticky_state", state_o, 2'd0);
    check("to_sticky", mem_timeout, 1'b1);
    step();
    check("to_sticky2", mem_timeout, 1'b1);

    // Reset asserted in the middle of a memory wait.
    hz.dmem_req_w = 1;
    step();
    step();
    check("rmw_state_pre", state_o, 2'd2);
    rst_n = 0;
    #1;
    check("rmw_ctl", ctl(), 6'b000000);
    check("rmw_state", state_o, 2'd0);
    check("rmw_timeout", mem_timeout, 1'b0);
    idle();
    #1;
    rst_n = 1;
    step();
    check("rmw_after_state", state_o, 2'd0);
    check("rmw_after_ctl", ctl(), 6'b000001);

`ifdef HAZARD_PERF_EN
    check("perf_rst", {stall_cnt, flush_cnt, lu_cnt}, 9'd0);
    load_e(5); hz.rs1_d = 5;
    step();
    idle();
    hz.pc_src_e = 1;
    step();
    idle();
    check("perf_lu", lu_cnt, 3'd1);
    check("perf_flush", flush_cnt, 3'd1);
    check("perf_stall1", stall_cnt, 3'd1);
    hz.dmem_req_w = 1;
    repeat (6) step();
    check("perf_stall7", stall_cnt, 3'd7);
    step();
    check("perf_stall_wrap", stall_cnt, 3'd0);
    idle();
    step();
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end
endmodule
